// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction-fetch and data requesters
module mem_arbiter #(
  parameter int MAXWAIT = 15,
  parameter int STARVE  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        stall,
  output logic        err
);
  localparam int WW = $clog2(MAXWAIT + 1);
  localparam int SW = $clog2(STARVE + 1);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  state_t        r_state;
  logic [WW-1:0] r_wait_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic          w_i_ok, w_d_ok, w_starved, w_pick_d, w_timeout;
  // a port whose ready is still high is finishing and must not be re-granted
  assign w_i_ok    = i_req & ~i_ready;
  assign w_d_ok    = d_req & ~d_ready;
  assign w_starved = r_starve_cnt == SW'(STARVE);
  assign w_pick_d  = w_d_ok & ~(w_i_ok & w_starved);
  assign w_timeout = r_wait_cnt == WW'(MAXWAIT - 1);
  assign stall     = (i_req & ~i_ready) | (d_req & ~d_ready);
  // arbitration FSM: grants latch the shared-port command, completion or timeout returns to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      m_req        <= 1'b0;
      m_we         <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      err          <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      err     <= 1'b0;
      if (r_state == IDLE) begin
        if (w_pick_d) begin
          r_state      <= D_BUSY;
          m_req        <= 1'b1;
          m_we         <= d_we;
          m_addr       <= d_addr;
          m_wdata      <= d_wdata;
          r_wait_cnt   <= '0;
          r_starve_cnt <= !i_req ? '0 : w_starved ? r_starve_cnt : r_starve_cnt + SW'(1);
        end else if (w_i_ok) begin
          r_state      <= I_BUSY;
          m_req        <= 1'b1;
          m_we         <= 1'b0;
          m_addr       <= i_addr;
          m_wdata      <= '0;
          r_wait_cnt   <= '0;
          r_starve_cnt <= '0;
        end
      end else if (m_ack || w_timeout) begin
        r_state <= IDLE;
        m_req   <= 1'b0;
        err     <= ~m_ack;
        if (r_state == I_BUSY) begin
          i_ready <= 1'b1;
          i_rdata <= m_ack ? m_rdata : '0;
        end else begin
          d_ready <= 1'b1;
          if (!m_we) d_rdata <= m_ack ? m_rdata : '0;
        end
      end else begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for the fetch/data memory arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ack = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we, stall, err;
  int          n_vec = 0, n_bad = 0;

  mem_arbiter #(.MAXWAIT(15), .STARVE(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_ready", {30'd0, i_ready, d_ready}, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    reset = 1'b1;
    // fetch only, ack in second busy cycle
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h40;
    #1 chk("f_stall_req", 32'(stall), 1);
    @(negedge clk);
    chk("f_m_req", 32'(m_req), 1);
    chk("f_m_addr", m_addr, 32'h40);
    chk("f_m_we", 32'(m_we), 0);
    chk("f_stall_busy", 32'(stall), 1);
    @(negedge clk);
    chk("f_stall_busy2", 32'(stall), 1);
    m_ack = 1'b1; m_rdata = 32'h8C020004;
    @(negedge clk);
    m_ack = 1'b0;
    chk("f_i_ready", 32'(i_ready), 1);
    chk("f_i_rdata", i_rdata, 32'h8C020004);
    chk("f_m_req_low", 32'(m_req), 0);
    chk("f_stall_done", 32'(stall), 0);
    i_req = 1'b0;
    @(negedge clk);
    chk("f_i_ready_pulse", 32'(i_ready), 0);
    // ack while idle is ignored
    m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    m_ack = 1'b0;
    chk("idle_ack_ready", {30'd0, i_ready, d_ready}, 0);
    chk("idle_ack_m_req", 32'(m_req), 0);
    chk("idle_ack_rdata", i_rdata, 32'h8C020004);
    // simultaneous: data store first, fetch at the d_ready edge
    i_req = 1'b1; i_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("s_m_we", 32'(m_we), 1);
    chk("s_m_addr", m_addr, 32'h80);
    chk("s_m_wdata", m_wdata, 32'hDEADBEEF);
    chk("s_starve1", 32'(dut.r_starve_cnt), 1);
    m_ack = 1'b1; m_rdata = 32'h5555_5555;
    @(negedge clk);
    m_ack = 1'b0;
    chk("s_d_ready", 32'(d_ready), 1);
    chk("s_d_rdata_kept", d_rdata, 0);
    chk("s_m_req_low", 32'(m_req), 0);
    @(negedge clk);
    d_req = 1'b0;
    chk("s_fetch_m_req", 32'(m_req), 1);
    chk("s_fetch_addr", m_addr, 32'h44);
    chk("s_fetch_we_wd", {m_wdata[30:0], m_we}, 0);
    chk("s_d_ready_pulse", 32'(d_ready), 0);
    chk("s_starve0", 32'(dut.r_starve_cnt), 0);
    m_ack = 1'b1; m_rdata = 32'h11;
    @(negedge clk);
    m_ack = 1'b0;
    chk("s_i_rdata", i_rdata, 32'h11);
    i_req = 1'b0;
    @(negedge clk);
    chk("s_idle", 32'(m_req), 0);
    // starvation: three data grants each made while a fetch is pending
    for (int k = 1; k <= 3; k++) begin
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100 + 32'(4 * k);
      @(negedge clk);
      i_req = 1'b0;
      chk("st_d_addr", m_addr, 32'h100 + 32'(4 * k));
      chk("st_cnt", 32'(dut.r_starve_cnt), 32'(k));
      m_ack = 1'b1; m_rdata = 32'hA0 + 32'(k);
      @(negedge clk);
      m_ack = 1'b0;
      chk("st_d_rdata", d_rdata, 32'hA0 + 32'(k));
      d_req = 1'b0;
      @(negedge clk);
    end
    i_req = 1'b1; d_req = 1'b1; d_addr = 32'h180;
    @(negedge clk);
    chk("st_fetch_addr", m_addr, 32'h200);
    chk("st_fetch_we", 32'(m_we), 0);
    chk("st_cnt_clr", 32'(dut.r_starve_cnt), 0);
    d_req = 1'b0;
    m_ack = 1'b1; m_rdata = 32'h22;
    @(negedge clk);
    m_ack = 1'b0;
    chk("st_i_ready", 32'(i_ready), 1);
    i_req = 1'b0;
    @(negedge clk);
    // timeout on a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    @(negedge clk);
    chk("to_m_req", 32'(m_req), 1);
    repeat (14) @(negedge clk);
    chk("to_still_busy", 32'(m_req), 1);
    chk("to_no_err_yet", 32'(err), 0);
    @(negedge clk);
    chk("to_d_ready", 32'(d_ready), 1);
    chk("to_err", 32'(err), 1);
    chk("to_d_rdata", d_rdata, 0);
    chk("to_m_req_low", 32'(m_req), 0);
    d_req = 1'b0;
    @(negedge clk);
    chk("to_err_pulse", 32'(err), 0);
    // ack in the timeout cycle wins
    d_req = 1'b1; d_addr = 32'h304;
    @(negedge clk);
    repeat (14) @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'h1234;
    @(negedge clk);
    m_ack = 1'b0;
    chk("col_d_rdata", d_rdata, 32'h1234);
    chk("col_err", 32'(err), 0);
    chk("col_d_ready", 32'(d_ready), 1);
    d_req = 1'b0;
    @(negedge clk);
    // reset mid-transaction
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hCAFE;
    @(negedge clk);
    chk("rm_busy", 32'(m_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("rm_m_req", 32'(m_req), 0);
    chk("rm_m_cmd", m_addr | m_wdata | 32'(m_we), 0);
    chk("rm_d_rdata", d_rdata, 0);
    chk("rm_pulses", {29'd0, i_ready, d_ready, err}, 0);
    @(negedge clk);
    reset = 1'b1;
    chk("rm_held", 32'(m_req), 0);
    @(negedge clk);
    chk("rm_regrant", 32'(m_req), 1);
    chk("rm_regrant_addr", m_addr, 32'h400);
    chk("rm_regrant_wd", m_wdata, 32'hCAFE);
    chk("rm_no_ready", 32'(d_ready), 0);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("rm_d_ready", 32'(d_ready), 1);
    d_req = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
